// File: rtl/ctrl.sv
// Instruction decoder and control unit for the 9-bit datapath.
// Combinational decode plus a sticky halt flag.
module ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] instruction,
   output logic [2:0] alu_op,
   output logic       reg_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       branch,
   output logic       branch_conditional,
   output logic       halted
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_XOR = 3'b011,
      OP_LDR = 3'b100,
      OP_STR = 3'b101,
      OP_BR  = 3'b110,
      OP_BRZ = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_XOR = 3'b011
   } alu_e;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_e;

   typedef struct packed {
      alu_e alu;
      logic rw;
      logic mr;
      logic mw;
      logic br;
      logic bc;
   } ctl_t;

   opcode_e    opc;
   logic [5:0] fields;
   logic       is_halt;
   logic       is_br;
   state_e     state_q;
   state_e     state_d;
   ctl_t       dec;
   ctl_t       ctl;

   assign opc     = opcode_e'(instruction[8:6]);
   assign fields  = instruction[5:0];
   assign is_halt = (opc == OP_BR) && (fields == 6'h3f);
   assign is_br   = (opc == OP_BR) && (fields != 6'h3f);

   // Halt flag register; async clear on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: HALT parks the unit until reset.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RUN:  if (is_halt) state_d = S_HALT;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RUN;
      endcase
   end

   // Raw opcode decode; HALT yields no enables.
   always_comb begin
      dec = '0;
      dec.alu = ALU_ADD;
      unique case (1'b1)
         opc == OP_ADD: begin
            dec.alu = ALU_ADD;
            dec.rw  = 1'b1;
         end
         opc == OP_SUB: begin
            dec.alu = ALU_SUB;
            dec.rw  = 1'b1;
         end
         opc == OP_AND: begin
            dec.alu = ALU_AND;
            dec.rw  = 1'b1;
         end
         opc == OP_XOR: begin
            dec.alu = ALU_XOR;
            dec.rw  = 1'b1;
         end
         opc == OP_LDR: begin
            dec.alu = ALU_ADD;
            dec.rw  = 1'b1;
            dec.mr  = 1'b1;
         end
         opc == OP_STR: begin
            dec.alu = ALU_ADD;
            dec.mw  = 1'b1;
         end
         is_br: begin
            dec.alu = ALU_ADD;
            dec.br  = 1'b1;
         end
         is_halt: begin
            dec.alu = ALU_ADD;
         end
         opc == OP_BRZ: begin
            dec.alu = ALU_SUB;
            dec.br  = 1'b1;
            dec.bc  = 1'b1;
         end
         default: begin
            dec = '0;
         end
      endcase
   end

   // Once halted, every control line is held idle.
   always_comb begin
      ctl = dec;
      if (state_q == S_HALT) begin
         ctl = '0;
      end
   end

   assign alu_op             = ctl.alu;
   assign reg_write          = ctl.rw;
   assign mem_read           = ctl.mr;
   assign mem_write          = ctl.mw;
   assign branch             = ctl.br;
   assign branch_conditional = ctl.bc;
   assign halted             = (state_q == S_HALT);

endmodule

// File: tb/tb_ctrl.sv
// Self-checking bench for ctrl: reference model plus
// directed vectors with literal expectations.
module tb_ctrl;

   logic       clk;
   logic       rst_n;
   logic [8:0] instruction;
   logic [2:0] alu_op;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic       branch;
   logic       branch_conditional;
   logic       halted;

   int checks = 0;
   int errors = 0;
   logic run_cmp = 1'b0;
   logic m_halt;

   localparam logic [8:0] HALT = 9'b110111111;

   ctrl dut (
      .clk(clk),
      .rst_n(rst_n),
      .instruction(instruction),
      .alu_op(alu_op),
      .reg_write(reg_write),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .branch(branch),
      .branch_conditional(branch_conditional),
      .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the halt flag
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_halt <= 1'b0;
      else if (instruction == HALT) m_halt <= 1'b1;
   end

   // Expected {alu_op, rw, mr, mw, br, bc} from the opcode table
   function automatic logic [7:0] model(input logic [8:0] ins,
                                        input logic h);
      logic [2:0] a;
      logic [4:0] e;
      a = 3'd0;
      e = 5'b0;
      if (!h) begin
         case (ins[8:6])
            3'd0: begin a = 3'd0; e = 5'b10000; end
            3'd1: begin a = 3'd1; e = 5'b10000; end
            3'd2: begin a = 3'd2; e = 5'b10000; end
            3'd3: begin a = 3'd3; e = 5'b10000; end
            3'd4: begin a = 3'd0; e = 5'b11000; end
            3'd5: begin a = 3'd0; e = 5'b00100; end
            3'd6: begin
               a = 3'd0;
               e = (ins[5:0] == 6'h3f) ? 5'b00000 : 5'b00010;
            end
            default: begin a = 3'd1; e = 5'b00011; end
         endcase
      end
      return {a, e};
   endfunction

   function automatic logic [7:0] dut_word();
      return {alu_op, reg_write, mem_read, mem_write,
              branch, branch_conditional};
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Every-cycle compare against the model
   always @(negedge clk) begin
      if (run_cmp) begin
         chk("cyc_halted", 32'(halted), 32'(m_halt));
         chk("cyc_ctl", 32'(dut_word()),
             32'(model(instruction, m_halt)));
         chk("inv_bc", 32'(branch_conditional & ~branch), 0);
         chk("inv_mem", 32'(mem_read & mem_write), 0);
      end
   end

   task automatic step(input logic [8:0] v);
      @(posedge clk);
      #2 instruction = v;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      instruction = 9'b000000000;
      #1;
      chk("rst_halted", 32'(halted), 0);
      chk("rst_add", 32'(dut_word()), 32'b000_10000);
      #1 instruction = 9'b001000000;
      #1;
      chk("rst_sub", 32'(dut_word()), 32'b001_10000);
      @(negedge clk);
      rst_n = 1'b1;
      run_cmp = 1'b1;

      step(9'b100000000);
      chk("ldr", 32'(dut_word()), 32'b000_11000);
      step(9'b101000000);
      chk("str", 32'(dut_word()), 32'b000_00100);
      step(9'b111000000);
      chk("brz", 32'(dut_word()), 32'b001_00011);
      step(9'b110000101);
      chk("br", 32'(dut_word()), 32'b000_00010);
      step(9'b010000000);
      chk("and", 32'(dut_word()), 32'b010_10000);
      step(9'b011000000);
      chk("xor", 32'(dut_word()), 32'b011_10000);
      step(9'b110111110);
      chk("br_near_halt", 32'(dut_word()), 32'b000_00010);

      for (int i = 0; i < 512; i++) begin
         if (9'(i) != HALT) step(9'(i));
      end
      chk("no_halt_yet", 32'(halted), 0);

      step(HALT);
      chk("halt_cycle_flag", 32'(halted), 0);
      chk("halt_cycle_ctl", 32'(dut_word()), 0);
      @(posedge clk);
      #1 chk("halt_set", 32'(halted), 1);
      step(9'b000000000);
      chk("halt_add", 32'(dut_word()), 0);
      step(9'b111000000);
      chk("halt_brz", 32'(dut_word()), 0);

      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_clr", 32'(halted), 0);
      chk("resume_add", 32'(dut_word()), 32'b001_00011);
      instruction = 9'b000000000;
      #1 chk("resume_rw", 32'(reg_write), 1);
      #1 rst_n = 1'b1;

      @(posedge clk);
      #2 rst_n = 1'b0;
      instruction = HALT;
      @(posedge clk);
      @(posedge clk);
      #1 chk("halt_in_rst", 32'(halted), 0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("halt_after_rst", 32'(halted), 1);

      step(9'b000000000);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("final_clr", 32'(halted), 0);
      run_cmp = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
